reg_writeback: RTL and testbench

//  Writeback stage directly upstream of the register file. Collects ALU results and

---
 rtl/reg_writeback.sv | 136 +++++++++++++
 tb/tb_reg_writeback.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Writeback stage ahead of the register file.
// ALU results and returning load data enter an in-order FIFO. The FIFO drains one
// entry per cycle onto the register file write port. A pending-destination
// scoreboard drives the decode hazard output.
module reg_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_issue,
    output logic              ld_issue_ok,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_resp_valid,
    input  logic [DATA_W-1:0] ld_resp_data,
    input  logic              wr_hold,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en,
    input  logic [ADDR_W-1:0] hz_addr1,
    input  logic [ADDR_W-1:0] hz_addr2,
    output logic              hazard,
    output logic              wb_idle,
    output logic              ro_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int NREGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    // Registers 0xD..0xF are read-only; writes to them are swallowed.
    localparam logic [ADDR_W-1:0] RO_FIRST = ADDR_W'(13);

    // FIFO storage (data path, not reset) and control state
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              ld_pend;
    logic [ADDR_W-1:0] ld_slot_addr;

    logic              alu_acc;
    logic              resp_acc;
    logic              issue_acc;
    logic              accept_any;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;
    logic              push_is_ro;
    logic              push_en;
    logic              pop_en;
    logic              fifo_empty;
    logic [NREGS-1:0]  pending;
    logic [PTR_W-1:0]  offset;

    // The slot reserved for an outstanding load is counted against ALU space,
    // so the returning response (which cannot be stalled) always has room.
    assign fifo_empty  = (count == '0);
    assign ld_issue_ok = !ld_pend && (count < DEPTH_C);
    assign alu_ready   = !ld_resp_valid && ((count + CNT_W'(ld_pend)) < DEPTH_C);

    assign alu_acc    = alu_valid && alu_ready;
    assign resp_acc   = ld_resp_valid && ld_pend;
    assign issue_acc  = ld_issue && ld_issue_ok;
    assign accept_any = alu_acc || resp_acc;

    // alu_ready is low whenever a response arrives, so the two sources never collide.
    assign push_addr  = resp_acc ? ld_slot_addr : alu_addr;
    assign push_data  = resp_acc ? ld_resp_data : alu_data;
    assign push_is_ro = (push_addr >= RO_FIRST);
    assign push_en    = accept_any && !push_is_ro;

    // Drain port: head of FIFO, zeroed while no write is presented.
    assign write_en   = !fifo_empty && !wr_hold;
    assign pop_en     = write_en;
    assign write_addr = write_en ? fifo_addr[rd_ptr] : '0;
    assign write_data = write_en ? fifo_data[rd_ptr] : '0;

    assign wb_idle = fifo_empty && !ld_pend;
    assign hazard  = pending[hz_addr1] | pending[hz_addr2];

    // Scoreboard: mark destinations of every live FIFO entry and the load slot.
    always_comb begin
        pending = '0;
        offset  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if ({1'b0, offset} < count) begin
                pending[fifo_addr[i]] = 1'b1;
            end
        end
        if (ld_pend) begin
            pending[ld_slot_addr] = 1'b1;
        end
    end

    // Entry storage and load destination capture; contents are qualified by count/ld_pend.
    always_ff @(posedge clock) begin
        if (push_en) begin
            fifo_addr[wr_ptr] <= push_addr;
            fifo_data[wr_ptr] <= push_data;
        end
        if (issue_acc) begin
            ld_slot_addr <= ld_addr;
        end
    end

    // Pointer, occupancy, load-slot and sticky error control.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ld_pend <= 1'b0;
            ro_err  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_en);
            rd_ptr <= rd_ptr + PTR_W'(pop_en);
            count  <= count + CNT_W'(push_en) - CNT_W'(pop_en);
            if (issue_acc) begin
                ld_pend <= 1'b1;
            end else if (resp_acc) begin
                ld_pend <= 1'b0;
            end
            if (accept_any && push_is_ro) begin
                ro_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: random and directed traffic against a
// queue-based reference model, with a separate monitor checking the write port.
module tb_reg_writeback;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [3:0]  alu_addr = '0;
    logic [15:0] alu_data = '0;
    logic        ld_issue = 1'b0;
    logic        ld_issue_ok;
    logic [3:0]  ld_addr = '0;
    logic        ld_resp_valid = 1'b0;
    logic [15:0] ld_resp_data = '0;
    logic        wr_hold = 1'b0;
    logic [3:0]  write_addr;
    logic [15:0] write_data;
    logic        write_en;
    logic [3:0]  hz_addr1 = '0;
    logic [3:0]  hz_addr2 = '0;
    logic        hazard;
    logic        wb_idle;
    logic        ro_err;

    always #5 clock = ~clock;

    reg_writeback #(.DEPTH(DEPTH), .DATA_W(16), .ADDR_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .ld_issue     (ld_issue),
        .ld_issue_ok  (ld_issue_ok),
        .ld_addr      (ld_addr),
        .ld_resp_valid(ld_resp_valid),
        .ld_resp_data (ld_resp_data),
        .wr_hold      (wr_hold),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_en     (write_en),
        .hz_addr1     (hz_addr1),
        .hz_addr2     (hz_addr2),
        .hazard       (hazard),
        .wb_idle      (wb_idle),
        .ro_err       (ro_err)
    );

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    // Reference model: expected register-file writes in order, plus load slot state.
    ent_t        expq[$];
    bit          m_pend = 1'b0;
    logic [3:0]  m_ld_addr = '0;
    bit          m_ro = 1'b0;

    // Effects decided this cycle, applied once the clock edge has happened.
    bit          st_push = 1'b0;
    bit          st_resp = 1'b0;
    bit          st_issue = 1'b0;
    bit          st_ro = 1'b0;
    ent_t        st_ent = '0;
    logic [3:0]  st_issue_addr = '0;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_pending(input logic [3:0] a);
        if (m_pend && m_ld_addr == a) return 1'b1;
        foreach (expq[i]) if (expq[i].a == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic commit();
        if (st_push) expq.push_back(st_ent);
        if (st_resp) m_pend = 1'b0;
        if (st_issue) begin
            m_pend    = 1'b1;
            m_ld_addr = st_issue_addr;
        end
        if (st_ro) m_ro = 1'b1;
        st_push = 1'b0; st_resp = 1'b0; st_issue = 1'b0; st_ro = 1'b0;
    endtask

    task automatic accept_write(input logic [3:0] a, input logic [15:0] d);
        if (a >= 4'hD) st_ro = 1'b1;
        else begin
            st_push = 1'b1;
            st_ent  = '{a: a, d: d};
        end
    endtask

    // One clock of stimulus: drive after the edge, check combinational outputs
    // against the model, then record what the coming edge will accept.
    task automatic cycle(input bit av, input logic [3:0] aa, input logic [15:0] ad,
                         input bit li, input logic [3:0] la,
                         input bit lr, input logic [15:0] ld,
                         input bit hold, input logic [3:0] h1, input logic [3:0] h2);
        int  cnt;
        bit  e_ar, e_ok;
        @(posedge clock);
        #1;
        commit();
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_issue = li; ld_addr = la;
        ld_resp_valid = lr; ld_resp_data = ld;
        wr_hold = hold; hz_addr1 = h1; hz_addr2 = h2;
        #3;
        cnt  = expq.size();
        e_ar = !lr && ((cnt + int'(m_pend)) < DEPTH);
        e_ok = !m_pend && (cnt < DEPTH);
        chk("alu_ready", 32'(alu_ready), 32'(e_ar));
        chk("ld_issue_ok", 32'(ld_issue_ok), 32'(e_ok));
        chk("write_en", 32'(write_en), 32'(cnt != 0 && !hold));
        chk("wb_idle", 32'(wb_idle), 32'(cnt == 0 && !m_pend));
        chk("hazard", 32'(hazard), 32'(m_pending(h1) || m_pending(h2)));
        chk("ro_err", 32'(ro_err), 32'(m_ro));
        if (av && e_ar) accept_write(aa, ad);
        if (lr && m_pend) begin
            st_resp = 1'b1;
            accept_write(m_ld_addr, ld);
        end
        if (li && e_ok) begin
            st_issue      = 1'b1;
            st_issue_addr = la;
        end
    endtask

    task automatic idle(input bit hold, input logic [3:0] h1);
        cycle(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0, 16'h0, hold, h1, 4'h0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_wb_idle", 32'(wb_idle), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_ld_issue_ok", 32'(ld_issue_ok), 32'd1);
        chk("rst_hazard", 32'(hazard), 32'd0);
        chk("rst_ro_err", 32'(ro_err), 32'd0);
        chk("rst_write_port", {12'h0, write_addr, write_data}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        alu_valid = 1'b0; ld_issue = 1'b0; ld_resp_valid = 1'b0; wr_hold = 1'b0;
        hz_addr1 = '0; hz_addr2 = '0;
        expq.delete();
        m_pend = 1'b0; m_ro = 1'b0;
        st_push = 1'b0; st_resp = 1'b0; st_issue = 1'b0; st_ro = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every presented write must match the head of the expected queue.
    initial begin
        ent_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (write_en === 1'b1) begin
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_write at %0t: got addr %0h data %0h, expected no write",
                                 $time, write_addr, write_data);
                    end else begin
                        e = expq.pop_front();
                        chk("write_addr", 32'(write_addr), 32'(e.a));
                        chk("write_data", 32'(write_data), 32'(e.d));
                    end
                end else begin
                    chk("idle_write_port", {12'h0, write_addr, write_data}, 32'd0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog at %0t: got no finish, expected finish", $time);
        $fatal(1);
    end

    initial begin
        bit         av, li, lr, hold;
        logic [3:0] aa, la, h1, h2;
        logic [15:0] ad, ld;

        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs();
        reset = 1'b0;

        // Single ALU result into an empty FIFO appears on the next cycle.
        cycle(1'b1, 4'h3, 16'h1234, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0, 4'h3, 4'h0);
        idle(1'b0, 4'h3);
        idle(1'b0, 4'h3);

        // Fill the FIFO under hold, then release: four writes in order.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 4'(i + 1), 16'(16'hA000 + i), 1'b0, 4'h0, 1'b0, 16'h0, 1'b1, 4'h2, 4'h4);
        cycle(1'b1, 4'h9, 16'h5555, 1'b0, 4'h0, 1'b0, 16'h0, 1'b1, 4'h9, 4'h0);
        repeat (6) idle(1'b0, 4'h1);

        // Load to r5 reserves a slot; three ALU pushes fill the rest.
        cycle(1'b0, 4'h0, 16'h0, 1'b1, 4'h5, 1'b0, 16'h0, 1'b1, 4'h5, 4'h0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 4'(i + 6), 16'(16'hC000 + i), 1'b0, 4'h0, 1'b0, 16'h0, 1'b1, 4'h5, 4'h0);
        cycle(1'b1, 4'hA, 16'h7777, 1'b0, 4'h0, 1'b0, 16'h0, 1'b1, 4'h5, 4'h0);
        cycle(1'b0, 4'h0, 16'h0, 1'b1, 4'h8, 1'b1, 16'hBEEF, 1'b1, 4'h5, 4'h0);
        repeat (7) idle(1'b0, 4'h5);

        // Read-only target: accepted, never written, sticky error.
        cycle(1'b1, 4'hE, 16'hDEAD, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0, 4'hE, 4'h0);
        repeat (3) idle(1'b0, 4'hE);

        // Reset with entries and a load outstanding.
        cycle(1'b0, 4'h0, 16'h0, 1'b1, 4'h7, 1'b0, 16'h0, 1'b1, 4'h7, 4'h0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 4'(i + 1), 16'(16'h3000 + i), 1'b0, 4'h0, 1'b0, 16'h0, 1'b1, 4'h7, 4'h1);
        do_reset();
        // A late response after reset must be ignored.
        cycle(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b1, 16'h4444, 1'b0, 4'h7, 4'h0);
        repeat (2) idle(1'b0, 4'h7);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            av   = ($urandom_range(0, 1) == 1);
            aa   = 4'($urandom_range(0, 15));
            ad   = 16'($urandom);
            li   = ($urandom_range(0, 9) < 3);
            la   = 4'($urandom_range(0, 12));
            lr   = ($urandom_range(0, 9) < 3);
            ld   = 16'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            h1   = 4'($urandom_range(0, 15));
            h2   = 4'($urandom_range(0, 15));
            cycle(av, aa, ad, li, la, lr, ld, hold, h1, h2);
        end

        // Finish any outstanding load and drain.
        cycle(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b1, 16'h6060, 1'b0, 4'h0, 4'h0);
        repeat (8) idle(1'b0, 4'h0);
        chk("drain_complete", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
